// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath widths, the canonical NOP and the fetch-buffer entry.
package cpu_pkg;
   localparam int XLEN = 64;
   localparam int ILEN = 32;
   localparam logic [ILEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [ILEN-1:0] instr;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry circular queue of fetch_entry_t with push/pop/flush and full/empty.
module fetch_fifo
   import cpu_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic         push_i,
   input  fetch_entry_t push_data_i,
   input  logic         pop_i,
   input  logic         flush_i,
   output fetch_entry_t head_o,
   output logic         full_o,
   output logic         empty_o
);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] PTR_ONE  = 1;
   localparam logic [PW:0]   CNT_ONE  = 1;
   localparam logic [PW:0]   CNT_FULL = (PW+1)'(DEPTH);

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW:0]   count_q, count_d;
   fetch_entry_t  mem_q [DEPTH];

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
         case ({push_i, pop_i})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; validity is tracked entirely by count_q.
   always_ff @(posedge clk_i) begin
      if (push_i && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CNT_FULL);
   assign empty_o = (count_q == '0);
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC register feeding a small fetch buffer toward decode, with redirect flush.
// Optional FETCH_PERF_EN adds push and decode-stall counters.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int          DEPTH    = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   output logic [31:0] imem_addr_o,
   input  logic [31:0] imem_rdata_i,
   input  logic        redirect_valid_i,
   input  logic [63:0] redirect_pc_i,
   input  logic        id_ready_i,
   output logic        id_valid_o,
   output logic [31:0] id_instr_o,
   output logic [63:0] id_pc_o
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetched_o,
   output logic [31:0] perf_stall_o
`endif
);
   localparam logic [63:0] PC_RST = {RESET_PC[63:2], 2'b00};

   logic [63:0]  pc_q, pc_d;
   logic         push, pop, full, empty;
   fetch_entry_t push_entry, head;

   fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .push_i      (push),
      .push_data_i (push_entry),
      .pop_i       (pop),
      .flush_i     (redirect_valid_i),
      .head_o      (head),
      .full_o      (full),
      .empty_o     (empty)
   );

   // Redirect wins over everything: it suppresses both push and pop.
   always_comb begin
      pop              = id_valid_o && id_ready_i && !redirect_valid_i;
      push             = !redirect_valid_i && (!full || pop);
      push_entry.pc    = pc_q;
      push_entry.instr = imem_rdata_i;
      pc_d             = pc_q;
      if (redirect_valid_i) pc_d = {redirect_pc_i[63:2], 2'b00};
      else if (push)        pc_d = pc_q + 64'd4;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) pc_q <= PC_RST;
      else        pc_q <= pc_d;
   end

   assign imem_addr_o = pc_q[33:2];
   assign id_valid_o  = !empty;
   assign id_instr_o  = id_valid_o ? head.instr : NOP_INSTR;
   assign id_pc_o     = id_valid_o ? head.pc : 64'h0;

`ifdef FETCH_PERF_EN
   logic [31:0] fetched_q, fetched_d;
   logic [31:0] stall_q, stall_d;

   always_comb begin
      fetched_d = fetched_q;
      stall_d   = stall_q;
      if (push)                     fetched_d = fetched_q + 32'd1;
      if (id_valid_o && !id_ready_i) stall_d  = stall_q + 32'd1;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         fetched_q <= '0;
         stall_q   <= '0;
      end else begin
         fetched_q <= fetched_d;
         stall_q   <= stall_d;
      end
   end

   assign perf_fetched_o = fetched_q;
   assign perf_stall_o   = stall_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus random ready/redirect traffic checked against a queue model.
module tb_fetch_unit;
   localparam int DEPTH = 2;

   logic        clk = 1'b0;
   logic        rst_i;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [63:0] redirect_pc;
   logic        id_ready;
   logic        id_valid;
   logic [31:0] id_instr;
   logic [63:0] id_pc;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetched;
   logic [31:0] perf_stall;
`endif

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'hA5A50000;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   fetch_unit #(.RESET_PC(64'h0), .DEPTH(DEPTH)) dut (
      .clk_i            (clk),
      .rst_i            (rst_i),
      .imem_addr_o      (imem_addr),
      .imem_rdata_i     (imem_rdata),
      .redirect_valid_i (redirect_valid),
      .redirect_pc_i    (redirect_pc),
      .id_ready_i       (id_ready),
      .id_valid_o       (id_valid),
      .id_instr_o       (id_instr),
      .id_pc_o          (id_pc)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched_o   (perf_fetched),
      .perf_stall_o     (perf_stall)
`endif
   );

   typedef struct {
      logic [63:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        q[$];
   logic [63:0] m_pc;
   logic [31:0] m_fetched;
   logic [31:0] m_stall;
   int          n_checks = 0;
   int          n_errors = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_pc      = 64'h0;
      m_fetched = 0;
      m_stall   = 0;
   endtask

   // One clock of the abstract fetch rules applied to the queue model.
   task automatic model_clock(input logic rdy, input logic redir, input logic [63:0] rpc);
      bit had, popped;
      had = q.size() > 0;
      if (had && !rdy) m_stall++;
      if (redir) begin
         q.delete();
         m_pc = {rpc[63:2], 2'b00};
      end else begin
         popped = had && rdy;
         if (popped) void'(q.pop_front());
         if (q.size() < DEPTH) begin
            q.push_back('{pc: m_pc, instr: mem_word(m_pc[33:2])});
            m_pc = m_pc + 64'd4;
            m_fetched++;
         end
      end
   endtask

   task automatic compare();
      check("valid", {63'h0, id_valid}, {63'h0, q.size() > 0});
      if (q.size() > 0) begin
         check("id_pc", id_pc, q[0].pc);
         check("id_instr", {32'h0, id_instr}, {32'h0, q[0].instr});
      end else begin
         check("idle_pc", id_pc, 64'h0);
         check("idle_instr", {32'h0, id_instr}, 64'h13);
      end
      check("imem_addr", {32'h0, imem_addr}, {32'h0, m_pc[33:2]});
`ifdef FETCH_PERF_EN
      check("perf_fetched", {32'h0, perf_fetched}, {32'h0, m_fetched});
      check("perf_stall", {32'h0, perf_stall}, {32'h0, m_stall});
`endif
   endtask

   // Called at a falling edge; leaves the bench at the next falling edge after checking.
   task automatic step(input logic rdy, input logic redir, input logic [63:0] rpc);
      id_ready       = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;
      @(posedge clk);
      model_clock(rdy, redir, rpc);
      @(negedge clk);
      compare();
   endtask

   task automatic do_reset();
      rst_i = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      compare();
      rst_i = 1'b1;
   endtask

   initial begin
      logic [63:0] rpc;
      logic        rdy, redir;
      rst_i          = 1'b0;
      id_ready       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 64'h0;
      model_reset();
      @(negedge clk);

      // Reset release with decode always ready: 0,4,8,12 back to back.
      do_reset();
      check("rst_valid", {63'h0, id_valid}, 64'h0);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 1'b0, 64'h0);
         check("stream_pc", id_pc, 64'(i * 4));
         check("stream_instr", {32'h0, id_instr}, {32'h0, mem_word(32'(i))});
      end

      // Decode stalled for 5 cycles: buffer fills, pc holds at 8.
      do_reset();
      for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 64'h0);
      check("stall_head_pc", id_pc, 64'h0);
      check("stall_imem_addr", {32'h0, imem_addr}, 64'h2);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 1'b0, 64'h0);
         check("drain_pc", id_pc, 64'(i * 4 + 4));
      end

      // Redirect while holding two entries.
      do_reset();
      step(1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b1, 64'h100);
      check("redir_bubble", {63'h0, id_valid}, 64'h0);
      step(1'b1, 1'b0, 64'h0);
      check("redir_target", id_pc, 64'h100);

      // Redirect coincident with full buffer and ready: no pop, flush, resume at target.
      step(1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 64'h0);
      step(1'b1, 1'b1, 64'h200);
      check("full_redir_bubble", {63'h0, id_valid}, 64'h0);
      step(1'b1, 1'b0, 64'h0);
      check("full_redir_target", id_pc, 64'h200);

      // Misaligned redirect target is forced to word alignment.
      step(1'b0, 1'b1, 64'h103);
      check("align_imem_addr", {32'h0, imem_addr}, 64'h40);
      step(1'b1, 1'b0, 64'h0);
      check("align_pc", id_pc, 64'h100);

      // Randomized traffic, including targets near the top of the address space.
      for (int i = 0; i < 400; i++) begin
         rdy   = ($urandom_range(0, 9) < 7);
         redir = ($urandom_range(0, 15) == 0);
         if ($urandom_range(0, 3) == 0) rpc = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
         else                           rpc = {$urandom, $urandom};
         step(rdy, redir, rpc);
      end

      // Asynchronous reset with full buffer clears the output immediately.
      step(1'b0, 1'b0, 64'h0);
      step(1'b0, 1'b0, 64'h0);
      #2 rst_i = 1'b0;
      #1;
      check("async_rst_valid", {63'h0, id_valid}, 64'h0);
      check("async_rst_pc", id_pc, 64'h0);
      check("async_rst_instr", {32'h0, id_instr}, 64'h13);
      check("async_rst_imem", {32'h0, imem_addr}, 64'h0);
`ifdef FETCH_PERF_EN
      check("async_rst_fetched", {32'h0, perf_fetched}, 64'h0);
      check("async_rst_stall", {32'h0, perf_stall}, 64'h0);
`endif
      @(negedge clk);
      do_reset();
      step(1'b1, 1'b0, 64'h0);
      check("post_rst_pc", id_pc, 64'h0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end
endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 64'h0, meaning the byte PC loaded on reset.
REQ-002 SHALL have parameter DEPTH, default 2, meaning fetch-buffer entries (power of two, >=2).
REQ-003 SHALL have port clk_i  input  1  clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port imem_addr_o  output  32  word index to instruction memory, equal to pc[33:2].
REQ-006 SHALL have port imem_rdata_i  input  32  instruction word returned combinationally for imem_addr_o.
REQ-007 SHALL have port redirect_valid_i  input  1  branch/jump redirect request.
REQ-008 SHALL have port redirect_pc_i  input  64  redirect target byte PC.
REQ-009 SHALL have port id_ready_i  input  1  decode accepts the head entry this cycle.
REQ-010 SHALL have port id_valid_o  output  1  head entry valid.
REQ-011 SHALL have port id_instr_o  output  32  head instruction.
REQ-012 SHALL have port id_pc_o  output  64  byte PC of head instruction.

Function
REQ-013 SHALL hold a 64-bit byte PC register; pc[1:0] always zero.
REQ-014 SHALL push {pc, imem_rdata_i} into the buffer and advance pc by 4 on a cycle when no redirect occurs and the buffer is not full or a pop occurs that same cycle.
REQ-015 SHALL pop the head entry when id_valid_o and id_ready_i are both high.
REQ-016 SHALL drive id_valid_o high exactly when the buffer holds at least one entry; first valid output appears one cycle after reset release.
REQ-017 SHALL drive id_instr_o = 32'h00000013 and id_pc_o = 0 whenever id_valid_o is low.
REQ-018 SHALL, when full with no pop, hold pc and perform no push (no instruction lost or duplicated).
REQ-019 SHALL, on redirect_valid_i, discard all buffered entries, suppress that cycle's push and pop, and load pc with {redirect_pc_i[63:2], 2'b00}; id_valid_o is low the following cycle.
REQ-020 SHALL give redirect priority over simultaneous push, pop and full conditions.
REQ-021 SHALL wrap buffer pointers modulo DEPTH and pc modulo 2^64 without error.
REQ-022 SHALL present entries to decode in strict program (push) order.

Reset
REQ-023 SHALL, while rst_i is low, force pc=RESET_PC, buffer empty, pointers 0, id_valid_o=0, id_instr_o=32'h00000013, id_pc_o=0.
REQ-024 SHALL, on reset assertion mid-operation, drop all buffered entries immediately and asynchronously.

Configuration
REQ-025 SHALL, with FETCH_PERF_EN defined, add outputs perf_fetched_o (32, counts pushes) and perf_stall_o (32, counts cycles with id_valid_o high and id_ready_i low), both reset to 0 and wrapping at 2^32.
REQ-026 SHALL, without FETCH_PERF_EN, omit those ports and counters entirely, with identical behaviour otherwise.

Structure
REQ-027 SHALL take XLEN=64, ILEN=32, NOP_INSTR=32'h00000013 and struct fetch_entry_t {pc, instr} from shared package cpu_pkg.
REQ-028 SHALL implement the buffer as sub-module fetch_fifo (DEPTH entries of fetch_entry_t, push/pop/flush, full/empty).

Verification
REQ-029 SHALL cover: reset release, RESET_PC=0, id_ready_i=1, memory words 0..3 = A0..A3 -> cycles 1..4 show id_pc_o 0,4,8,12 with instr A0..A3.
REQ-030 SHALL cover: id_ready_i=0 for 5 cycles -> buffer fills to DEPTH=2, pc holds at 8, id_pc_o stays 0; on release, 0,4,8 delivered with no gap or duplicate.
REQ-031 SHALL cover: redirect_valid_i pulse with redirect_pc_i=0x100 while buffer holds 2 entries -> next cycle id_valid_o=0, following cycle id_pc_o=0x100.
REQ-032 SHALL cover: redirect coincident with full buffer and id_ready_i=1 -> no pop counted, entries flushed, fetch resumes at target.
REQ-033 SHALL cover: redirect_pc_i=0x103 -> id_pc_o=0x100, imem_addr_o=0x40.
REQ-034 SHALL cover: rst_i asserted with buffer full -> id_valid_o=0 immediately; with FETCH_PERF_EN, perf_fetched_o and perf_stall_o read 0.
